// File: rtl/mQTree.sv
// Shared QTree_Int types: heap word and pointer layouts, node tags, child-field
// extraction, and the serializer's FSM state and stack-frame types.
package mQTree;

    localparam int QT_ADDR_W = 16;
    localparam int QT_WORD_W = 67;

    // bit0 = valid, [16:1] = heap address
    typedef logic [QT_ADDR_W:0]   Pointer_QTree_Int_t;
    // bit0 = valid, [2:1] = tag, [66:3] = payload
    typedef logic [QT_WORD_W-1:0] QTree_Int_t;

    typedef enum logic [1:0] {
        TAG_QNONE  = 2'd0,
        TAG_QVAL   = 2'd1,
        TAG_QNODE  = 2'd2,
        TAG_QERROR = 2'd3
    } qtree_tag_e;

    typedef logic [1:0] child_idx_t;

    // One pending QNode: its word plus the child currently being visited
    typedef struct packed {
        QTree_Int_t word;
        child_idx_t idx;
    } qframe_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_NEXT,
        S_ERR
    } ser_state_e;

    function automatic qtree_tag_e tag_of(input QTree_Int_t word);
        return qtree_tag_e'(word[2:1]);
    endfunction

    // payload is word[66:3]; children occupy consecutive 16-bit fields c0..c3
    function automatic logic [QT_ADDR_W-1:0] child_of(input logic [63:0] payload,
                                                       input child_idx_t idx);
        logic [QT_ADDR_W-1:0] child;
        unique case (idx)
            2'd0: child = payload[15:0];
            2'd1: child = payload[31:16];
            2'd2: child = payload[47:32];
            2'd3: child = payload[63:48];
        endcase
        return child;
    endfunction

endpackage

// File: rtl/qtree_frame_stack.sv
// LIFO of QNode frames for the postorder walk: push/pop, in-place update of
// the top frame's child index, combinational top and depth.
module qtree_frame_stack
    import mQTree::*;
#(
    parameter int DEPTH = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         upd_idx_i,
    input  child_idx_t                   idx_i,
    input  qframe_t                      push_frame_i,
    output qframe_t                      top_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o
);

    localparam int DEPTH_W = $clog2(DEPTH + 1);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    qframe_t              mem_q [DEPTH];
    logic [DEPTH_W-1:0]   depth_q, depth_d;
    logic [PTR_W-1:0]     wr_ptr, top_ptr;
    logic                 full, empty;

    assign full    = (depth_q == DEPTH_W'(DEPTH));
    assign empty   = (depth_q == '0);
    assign wr_ptr  = PTR_W'(depth_q);
    assign top_ptr = PTR_W'(depth_q - DEPTH_W'(1));
    assign top_o   = mem_q[top_ptr];
    assign depth_o = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (push_i && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop_i && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    // NOTE: frame storage has no reset; clearing depth_q alone makes every stale entry unreachable.
    always_ff @(posedge clk) begin
        if (push_i && !full) begin
            mem_q[wr_ptr] <= push_frame_i;
        end else if (upd_idx_i && !empty) begin
            mem_q[top_ptr].idx <= idx_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/qtree_int_serializer.sv
// Walks a QTree_Int held in a word-addressed heap and streams its nodes in
// postorder (c0..c3, then the node) as AXI-stream words; tlast marks the root.
module qtree_int_serializer
    import mQTree::*;
#(
    parameter int STACK_DEPTH = 64,
    parameter int ADDR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  Pointer_QTree_Int_t root_d,
    output logic               root_r,
    output Pointer_QTree_Int_t rd_addr_d,
    input  logic               rd_addr_r,
    input  QTree_Int_t         rd_data_d,
    output logic               rd_data_r,
    output QTree_Int_t         o_QTree_Int_tdata,
    output logic               o_QTree_Int_tvalid,
    input  logic               o_QTree_Int_tready,
    output logic               o_QTree_Int_tlast,
    output logic               err,
    output logic [15:0]        node_count
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    ser_state_e          state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    QTree_Int_t          out_q, out_d;
    logic [15:0]         node_count_q, node_count_d;

    logic                push, pop, upd_idx;
    child_idx_t          next_idx;
    qframe_t             push_frame, top;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_empty, stack_full;

    assign stack_empty = (depth == '0);
    assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign node_count  = node_count_q;

    qtree_frame_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk          (clk),
        .reset        (reset),
        .push_i       (push),
        .pop_i        (pop),
        .upd_idx_i    (upd_idx),
        .idx_i        (next_idx),
        .push_frame_i (push_frame),
        .top_o        (top),
        .depth_o      (depth)
    );

    // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
    always_comb begin
        state_d            = state_q;
        cur_d              = cur_q;
        out_d              = out_q;
        node_count_d       = node_count_q;
        push               = 1'b0;
        pop                = 1'b0;
        upd_idx            = 1'b0;
        next_idx           = top.idx + 2'd1;
        push_frame         = '{word: rd_data_d, idx: 2'd0};
        root_r             = 1'b0;
        rd_addr_d          = '0;
        rd_data_r          = 1'b0;
        o_QTree_Int_tdata  = '0;
        o_QTree_Int_tvalid = 1'b0;
        o_QTree_Int_tlast  = 1'b0;
        err                = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                root_r = 1'b1;
                if (root_d[0]) begin
                    cur_d        = root_d[ADDR_W:1];
                    node_count_d = '0;
                    state_d      = S_READ;
                end
            end
            S_READ: begin
                rd_addr_d = {cur_q, 1'b1};
                if (rd_addr_r) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                rd_data_r = 1'b1;
                if (rd_data_d[0]) begin
                    if (tag_of(rd_data_d) == TAG_QNODE) begin
                        if (stack_full) begin
                            state_d = S_ERR;
                        end else begin
                            push    = 1'b1;
                            cur_d   = child_of(rd_data_d[66:3], 2'd0);
                            state_d = S_READ;
                        end
                    end else begin
                        out_d   = rd_data_d;
                        state_d = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                o_QTree_Int_tvalid = 1'b1;
                o_QTree_Int_tdata  = {out_q[66:1], 1'b1};
                o_QTree_Int_tlast  = stack_empty;
                if (o_QTree_Int_tready) begin
                    node_count_d = node_count_q + 16'd1;
                    state_d      = stack_empty ? S_IDLE : S_NEXT;
                end
            end
            S_NEXT: begin
                // a node is emitted only after all four of its children
                if (top.idx != 2'd3) begin
                    upd_idx = 1'b1;
                    cur_d   = child_of(top.word[66:3], next_idx);
                    state_d = S_READ;
                end else begin
                    pop     = 1'b1;
                    out_d   = top.word;
                    state_d = S_EMIT;
                end
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            out_q        <= '0;
            node_count_q <= '0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            out_q        <= out_d;
            node_count_q <= node_count_d;
        end
    end

endmodule

// File: doc/qtree_int_serializer.md
QTREE_INT_SERIALIZER -- requirements
Module: qtree_int_serializer

Interface
Parameters (name, default, meaning):
- REQ-001 STACK_DEPTH, 64, maximum number of QNode frames held during traversal.
- REQ-002 ADDR_W, 16, heap pointer width; equals the Word16# pointer payload width.

Ports (name, direction, width, meaning):
- REQ-003 clk, in, 1, single clock. Reset is synchronous and active-high.
- REQ-004 reset, in, 1, synchronous active-high reset.
- REQ-005 root_d, in, 17 (Pointer_QTree_Int_t), root pointer; bit0 = valid, [16:1] = address.
- REQ-006 root_r, out, 1, ready for root_d.
- REQ-007 rd_addr_d, out, 17 (Pointer_QTree_Int_t), heap read request; bit0 = valid.
- REQ-008 rd_addr_r, in, 1, heap accepts the request.
- REQ-009 rd_data_d, in, 67 (QTree_Int_t), heap read response; bit0 = valid, [2:1] = tag, [66:3] = payload.
- REQ-010 rd_data_r, out, 1, ready for rd_data_d.
- REQ-011 o_QTree_Int_tdata, out, 67, streamed node word, in the same format as the QTree_Int AXI input.
- REQ-012 o_QTree_Int_tvalid / o_QTree_Int_tready / o_QTree_Int_tlast, out / in / out, 1 each, AXI-stream handshake.
- REQ-013 err, out, 1, sticky stack-overflow flag.
- REQ-014 node_count, out, 16, number of words emitted for the current tree.

Function
- REQ-015 Tags: 0 QNone, 1 QVal, 2 QNode, 3 QError. QNode children are at [18:3] c0, [34:19] c1, [50:35] c2, [66:51] c3.
- REQ-016 States: IDLE, READ, WAIT, EMIT, NEXT, ERR. Block SHALL emit the tree in postorder, children c0..c3 then the node, which is the format the QTree_Int stream reconstructor consumes.
- REQ-017 IDLE: root_r=1. On root_d[0]=1: latch cur=root_d[16:1], clear node_count, go to READ next cycle.
- REQ-018 READ: rd_addr_d={cur,1'b1}, held stable until rd_addr_r=1; then go to WAIT.
- REQ-019 WAIT: rd_data_r=1. On rd_data_d[0]=1:
  - tag 2: push frame {word, idx=0}, cur=c0, go to READ.
  - any other tag: out=word, go to EMIT.
- REQ-020 Push when depth==STACK_DEPTH SHALL go to ERR. In ERR: err=1, all valids 0, all readies 0, held until reset.
- REQ-021 EMIT: tvalid=1, tdata=out with bit0=1, tlast=(stack empty). tdata and tlast SHALL be held stable while tready=0.
- REQ-022 On EMIT handshake: node_count increments (wraps at 16 bits).
  - Stack empty: go to IDLE.
  - Otherwise: go to NEXT.
- REQ-023 NEXT: if top idx<3, set idx+1, cur=child[idx+1], go to READ. If idx==3, pop, out=frame word, go to EMIT.
- REQ-024 root_r=0 outside IDLE; root_d presented then is not consumed.
- REQ-025 rd_data_d arriving outside WAIT is ignored (rd_data_r=0).
- REQ-026 Minimum cost per word is 3 cycles (READ, WAIT, EMIT). NEXT adds 1 cycle per child transition.

Reset
- REQ-027 reset SHALL force IDLE with root_r=1 and stack depth 0.
- REQ-028 reset SHALL clear every output: rd_addr_d=0, rd_data_r=0, tvalid=0, tlast=0, tdata=0, err=0, node_count=0.
- REQ-029 Reset mid-traversal SHALL abandon the tree; no further words are emitted.

Structure
- REQ-030 QTree_Int_t, Pointer_QTree_Int_t, the tag constants and the child-extract helpers SHALL live in the shared mQTree package.
- REQ-031 The frame stack SHALL be one sub-module, qtree_frame_stack: push, pop, top, depth outputs; 67+2-bit entries.

Verification
- REQ-032 Root@5 = QVal 7: emit one word, tag 1, tlast=1, node_count=1, back to IDLE.
- REQ-033 Root@1 = QNode(2,3,4,5), children QVal 10..13: emit 10, 11, 12, 13, node; tlast only on the node; node_count=5.
- REQ-034 Depth-2 tree, 9 nodes, with tready toggled 0/1 every cycle: same postorder; tdata stable during stalls.
- REQ-035 rd_addr_r held 0 for 10 cycles: rd_addr_d constant and no state advance.
- REQ-036 Linear chain of 65 nested QNodes with STACK_DEPTH=64: err=1 and no tvalid after the overflow.
- REQ-037 reset asserted during the EMIT of the 2nd word of REQ-033: next cycle all outputs 0, root_r=1; a new root then traverses correctly.
